// File: rtl/div_monitor.sv
// div_monitor: measures the period and high phase of a divided clock (div_in)
// in clk cycles. It declares lock after LOCK_CNT consecutive measurements that
// match the expected ratio, and pulses err when an established lock is lost.
//
// state  | meaning
// IDLE   | monitor disabled, counters cleared
// ARM    | waiting for the first rise to start a fresh interval
// MEAS   | measuring every rise, counting consecutive matches
// LOCKED | measuring every rise, a mismatch or timeout drops lock
module div_monitor #(
  parameter int DIV_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_in,
  input  logic [DIV_W-1:0] expected,
  output logic [DIV_W-1:0] period,
  output logic [DIV_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARM    = 2'd1;
  localparam logic [1:0] MEAS   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
  localparam logic [MW-1:0] MCNT_LAST = MW'(LOCK_CNT - 1);
  localparam logic [DIV_W-1:0] ONES = {DIV_W{1'b1}};

  // Power pins carry no logic; tie them into an intentionally unused net.
  wire unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  logic [1:0]       state;
  logic [MW-1:0]    mcnt;
  logic             s1, s, s_d;
  logic             rise;
  logic [DIV_W-1:0] cnt, hcnt;
  logic [DIV_W-1:0] half_lo, half_hi;
  logic             match;
  logic             cnt_full;

  // Two-flop synchronizer for the asynchronous divided clock plus edge delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= div_in;
      s   <= s1;
      s_d <= s;
    end
  end

  assign rise     = s & ~s_d;
  assign cnt_full = (cnt == ONES);

  // A measurement matches on exact period and a high phase of floor or ceil of half.
  always_comb begin
    half_lo = expected >> 1;
    half_hi = half_lo + {{(DIV_W-1){1'b0}}, expected[0]};
    match   = (expected >= DIV_W'(2)) && (cnt == expected) &&
              ((hcnt == half_lo) || (hcnt == half_hi));
  end

  // Interval and high-phase counters: restart on each rise, saturate at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (!en) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= DIV_W'(1);
      hcnt <= DIV_W'(1);
    end else begin
      if (!cnt_full)
        cnt <= cnt + DIV_W'(1);
      if (s && (hcnt != ONES))
        hcnt <= hcnt + DIV_W'(1);
    end
  end

  // Lock FSM; a rise wins over a coincident timeout so the interval is still measured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mcnt       <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      if (!en) begin
        state  <= IDLE;
        locked <= 1'b0;
        mcnt   <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise)
              state <= MEAS;
          end
          MEAS, LOCKED: begin
            if (rise) begin
              period     <= cnt;
              high_time  <= hcnt;
              meas_valid <= 1'b1;
              if (match) begin
                if (state == MEAS) begin
                  if (mcnt == MCNT_LAST) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                  end else begin
                    mcnt <= mcnt + MW'(1);
                  end
                end
              end else begin
                mcnt <= '0;
                if (state == LOCKED) begin
                  locked <= 1'b0;
                  err    <= 1'b1;
                  state  <= MEAS;
                end
              end
            end else if (cnt_full) begin
              locked <= 1'b0;
              mcnt   <= '0;
              err    <= (state == LOCKED);
              state  <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_monitor.sv
// Scoreboard bench for div_monitor: scenarios push hand-computed measurement
// records; a negedge monitor pops one per meas_valid and compares.
module tb_div_monitor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         div_in;
  logic [W-1:0] expected;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         err;
  wire          vdd;
  wire          vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  div_monitor #(.DIV_W(W), .LOCK_CNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_in     (div_in),
    .expected   (expected),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err),
    .VDD        (vdd),
    .VSS        (vss)
  );

  typedef struct {
    int per;
    int hi;
    int lk;
    int er;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks    = 0;
  int   n_fail      = 0;
  int   err_cnt     = 0;
  int   mv_cnt      = 0;
  int   cyc         = 0;
  int   last_mv_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic push_one(input int per, input int hi, input int lk, input int er);
    exp_t e;
    e.per = per;
    e.hi  = hi;
    e.lk  = lk;
    e.er  = er;
    exp_q.push_back(e);
  endtask

  // n matching-shape records; locked expected from the lock_at-th one on (0 = never)
  task automatic push(input int n, input int per, input int hi, input int lock_at);
    for (int i = 1; i <= n; i++)
      push_one(per, hi, ((lock_at != 0) && (i >= lock_at)) ? 1 : 0, 0);
  endtask

  // n back-to-back periods of nd clk cycles, high for the first nh
  task automatic run_div(input int n, input int nd, input int nh);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < nd; c++) begin
        @(negedge clk);
        div_in = (c < nh);
      end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  // Monitor: one scoreboard pop per measurement, err pulses tallied.
  always @(negedge clk) begin
    if (err)
      err_cnt++;
    if (meas_valid) begin
      mv_cnt++;
      last_mv_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_meas: got period %0d, want no measurement", period);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", int'(period), mon_e.per);
        check("high_time", int'(high_time), mon_e.hi);
        check("locked_at_meas", int'(locked), mon_e.lk);
        check("err_at_meas", int'(err), mon_e.er);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int mv0;
    reset    = 1'b1;
    en       = 1'b0;
    div_in   = 1'b0;
    expected = W'(9);
    repeat (3) @(negedge clk);
    check("rst_period", int'(period), 0);
    check("rst_high_time", int'(high_time), 0);
    check("rst_meas_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);

    en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("state_arm_after_reset", int'(dut.state), 1);

    // Lock at divide-by-9, then switch to divide-by-10 and relock on expected=10
    push(4, 9, 4, 4);
    push_one(9, 4, 1, 0);
    push_one(10, 5, 0, 1);
    push(5, 10, 5, 4);
    run_div(5, 9, 4);
    run_div(2, 10, 5);
    expected = W'(10);
    run_div(5, 10, 5);
    drain();
    check("err_on_ratio_change", err_cnt, 1);

    // div_in stuck low while locked: timeout 255 cycles after last measurement
    t = 0;
    while (!err && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    check("timeout_seen", (t < 400) ? 1 : 0, 1);
    check("timeout_gap", cyc - last_mv_cyc, 255);
    check("timeout_locked", int'(locked), 0);
    check("timeout_state_arm", int'(dut.state), 1);
    repeat (20) @(negedge clk);
    check("timeout_err_once", err_cnt, 2);

    // Restart toggling with a 5-cycle high phase (ceil of 9/2)
    expected = W'(9);
    push(5, 9, 5, 4);
    run_div(6, 9, 5);
    drain();
    check("relock_no_err", err_cnt, 2);

    // Disable while locked: lock drops, measurements hold, no err
    en = 1'b0;
    @(negedge clk);
    check("dis_locked", int'(locked), 0);
    check("dis_period_hold", int'(period), 9);
    check("dis_high_hold", int'(high_time), 5);
    repeat (3) @(negedge clk);
    check("dis_no_err", err_cnt, 2);
    en = 1'b1;
    push(5, 9, 4, 4);
    run_div(6, 9, 4);
    drain();

    // Reset mid-measurement while locked
    check("pre_reset_locked", int'(locked), 1);
    @(negedge clk);
    div_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_period", int'(period), 0);
    check("arst_high_time", int'(high_time), 0);
    check("arst_meas_valid", int'(meas_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    div_in = 1'b0;
    reset  = 1'b0;
    push(4, 9, 4, 4);
    mv0 = mv_cnt;
    run_div(1, 9, 4);
    check("no_meas_first_rise", mv_cnt, mv0);
    run_div(4, 9, 4);
    drain();
    check("relock_after_reset", int'(locked), 1);
    check("reset_no_err", err_cnt, 2);

    // Wrong expected ratio: period still measured, never locks, no err
    en = 1'b0;
    repeat (3) @(negedge clk);
    expected = W'(8);
    en = 1'b1;
    push(5, 9, 4, 0);
    run_div(6, 9, 4);
    drain();
    check("exp8_locked", int'(locked), 0);
    check("exp8_no_err", err_cnt, 2);

    // Smallest matchable ratio: divide-by-2, high 1
    en = 1'b0;
    repeat (2) @(negedge clk);
    expected = W'(2);
    en = 1'b1;
    push(5, 2, 1, 4);
    run_div(6, 2, 1);
    drain();
    check("div2_locked", int'(locked), 1);

    check("queue_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_monitor.md
DIV_MONITOR -- requirements
Module: div_monitor

Interface
REQ-001 Parameter DIV_W, default 8: width of the period counters, the measurement outputs and `expected`.
REQ-002 Parameter LOCK_CNT, default 4: number of consecutive matching measurements required to assert `locked`.
REQ-003 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port `en`, input, 1 bit: 1 = monitor runs; 0 = monitor idles.
REQ-006 Port `div_in`, input, 1 bit: divided clock under test; asynchronous to `clk`.
REQ-007 Port `expected`, input, DIV_W bits: expected division ratio, in `clk` cycles.
REQ-008 Port `period`, output, DIV_W bits: last measured rising-to-rising interval, in `clk` cycles.
REQ-009 Port `high_time`, output, DIV_W bits: last measured high phase, in `clk` cycles.
REQ-010 Port `meas_valid`, output, 1 bit: one-cycle pulse when `period` and `high_time` update.
REQ-011 Port `locked`, output, 1 bit: `div_in` matches `expected` (see REQ-020).
REQ-012 Port `err`, output, 1 bit: one-cycle pulse on loss of lock.
REQ-013 Port `VDD`, inout, 1 bit: power pin; no logic function.
REQ-014 Port `VSS`, inout, 1 bit: ground pin; no logic function.

Function
REQ-015 `div_in` SHALL pass through a two-flop synchronizer to give `s`, followed by one delay flop `s_d`; rise = `s & ~s_d`.
REQ-016 FSM states SHALL be IDLE, ARM, MEAS and LOCKED.
- IDLE -> ARM when `en`=1.
- Any state -> IDLE when `en`=0, within 1 cycle.
REQ-017 Cycle counter `cnt`:
- loads 1 on a rise cycle;
- otherwise increments by 1 and saturates at all-ones.
REQ-018 High counter `hcnt`:
- loads 1 on a rise cycle;
- otherwise increments while `s`=1 and holds while `s`=0;
- saturates at all-ones.
REQ-019 Measurement on a rise:
- In ARM, a rise SHALL only load the counters, with no measurement, and move to MEAS.
- In MEAS or LOCKED, a rise SHALL load `period`<=`cnt` and `high_time`<=`hcnt`, and pulse `meas_valid` the next cycle.
REQ-020 A measurement matches when both hold:
- `period`==`expected`;
- `high_time` is floor(`expected`/2) or ceil(`expected`/2).
- `expected` < 2 SHALL never match.
REQ-021 Lock acquisition: a match counter SHALL count consecutive matches in MEAS and clear on any mismatch; on reaching LOCK_CNT the FSM SHALL enter LOCKED and set `locked`=1.
REQ-022 Lock loss: a mismatch in LOCKED SHALL clear `locked`, clear the match counter, pulse `err` for 1 cycle and return to MEAS.
REQ-023 Timeout: `cnt` reaching all-ones in MEAS or LOCKED SHALL:
- clear `locked`;
- pulse `err` only if the state was LOCKED;
- return to ARM.
REQ-024 Disable: `en`=0 SHALL clear `locked`, the match counter and both counters; `period` and `high_time` SHALL hold their last values; `err` SHALL NOT pulse.
REQ-025 A change of `expected` SHALL take effect at the next comparison; a change while LOCKED that causes a mismatch SHALL behave as REQ-022.
REQ-026 Rise cycle coinciding with timeout: the rise SHALL take priority and be measured normally.
REQ-027 A synchronized glitch (high for 1 cycle) SHALL be treated as a genuine rise and compared normally, with no filtering.

Reset
REQ-028 `reset`=1 SHALL immediately force:
- state = IDLE;
- synchronizer flops, `cnt`, `hcnt`, match counter, `period` and `high_time` = 0;
- `meas_valid`, `locked` and `err` = 0.
REQ-029 Release of `reset` with `en`=1 SHALL enter ARM on the first `clk` rising edge.
REQ-030 Assertion of `reset` while LOCKED SHALL clear `locked` without pulsing `err`.

Verification
REQ-031 Divide-by-9, 50%-duty `div_in`, `expected`=9, `en`=1 -> every `meas_valid` shows `period`=9 and `high_time` of 4 or 5; `locked` rises on the 4th `meas_valid`.
REQ-032 Same stimulus but `expected`=8 -> `period`=9 on every measurement; `locked` stays 0; `err` stays 0.
REQ-033 While locked, hold `div_in` low -> 255 cycles after the last rise `err` pulses once, `locked`=0, state ARM; restart toggling -> relock after 1+4 rises.
REQ-034 While locked, switch `div_in` to divide-by-10 -> first `period`=10 measurement clears `locked` and pulses `err`; with `expected`=10, relock after 4 more measurements.
REQ-035 Assert `reset` mid-measurement while locked -> all outputs 0 asynchronously, no `err`; after release, the first rise produces no `meas_valid`.
REQ-036 Drop `en` while locked -> `locked`=0 next cycle, no `err`, `period` holds 9; raise `en` -> lock after 5 rises.
